// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter between ALU and LSU with a register scoreboard.
// Grants one writeback per cycle round-robin, registers the write port, and stalls issue on busy registers.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    localparam int REG_BUS_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    input  logic [REG_BUS_WIDTH-1:0] issue_rs1,
    input  logic [REG_BUS_WIDTH-1:0] issue_rs2,
    input  logic [REG_BUS_WIDTH-1:0] issue_rd,
    input  logic                     issue_has_rd,
    output logic                     stall,
    input  logic                     alu_valid,
    input  logic [REG_BUS_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0]    alu_data,
    output logic                     alu_ready,
    input  logic                     lsu_valid,
    input  logic [REG_BUS_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0]    lsu_data,
    output logic                     lsu_ready,
    output logic                     write_enable,
    output logic [REG_BUS_WIDTH-1:0] rd,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic [NUM_REGS-1:0]      busy
);

    typedef enum logic {GRANT_ALU = 1'b0, GRANT_LSU = 1'b1} grant_e;

    grant_e                   last_grant_q, last_grant_d;
    logic [NUM_REGS-1:0]      busy_q, busy_d;
    logic                     we_q, we_d;
    logic [REG_BUS_WIDTH-1:0] rd_q, rd_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic                     stall_s;
    logic                     issue_fire_s;
    logic                     grant_alu_s;
    logic                     grant_lsu_s;

    // Hazard detection; busy_q[0] is never set so register 0 cannot stall.
    always_comb begin
        stall_s = 1'b0;
        if (!rst && issue_valid) begin
            stall_s = busy_q[issue_rs1] | busy_q[issue_rs2] | (issue_has_rd & busy_q[issue_rd]);
        end else begin
            stall_s = 1'b0;
        end
    end

    assign issue_fire_s = !rst && issue_valid && !stall_s;

    // Round-robin grant: on contention the requester not granted last wins.
    always_comb begin
        grant_alu_s = 1'b0;
        grant_lsu_s = 1'b0;
        if (rst) begin
            grant_alu_s = 1'b0;
            grant_lsu_s = 1'b0;
        end else begin
            case ({alu_valid, lsu_valid})
                2'b11: begin
                    grant_alu_s = (last_grant_q == GRANT_LSU);
                    grant_lsu_s = (last_grant_q == GRANT_ALU);
                end
                2'b10:   grant_alu_s = 1'b1;
                2'b01:   grant_lsu_s = 1'b1;
                default: begin
                    grant_alu_s = 1'b0;
                    grant_lsu_s = 1'b0;
                end
            endcase
        end
    end

    // Next write-port contents; a transfer to register 0 is accepted but not written.
    always_comb begin
        we_d         = 1'b0;
        rd_d         = rd_q;
        data_d       = data_q;
        last_grant_d = last_grant_q;
        if (grant_alu_s) begin
            we_d         = (alu_rd != {REG_BUS_WIDTH{1'b0}});
            rd_d         = alu_rd;
            data_d       = alu_data;
            last_grant_d = GRANT_ALU;
        end else if (grant_lsu_s) begin
            we_d         = (lsu_rd != {REG_BUS_WIDTH{1'b0}});
            rd_d         = lsu_rd;
            data_d       = lsu_data;
            last_grant_d = GRANT_LSU;
        end else begin
            we_d = 1'b0;
        end
    end

    // Scoreboard update: a same-edge set overrides the clear from the committing write.
    always_comb begin
        busy_d = {NUM_REGS{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            busy_d[i] = (i != 0) &&
                        ((issue_fire_s && issue_has_rd && (issue_rd == REG_BUS_WIDTH'(i))) ||
                         (busy_q[i] && !(we_q && (rd_q == REG_BUS_WIDTH'(i)))));
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q       <= {NUM_REGS{1'b0}};
            we_q         <= 1'b0;
            rd_q         <= {REG_BUS_WIDTH{1'b0}};
            data_q       <= {DATA_WIDTH{1'b0}};
            last_grant_q <= GRANT_LSU;
        end else begin
            busy_q       <= busy_d;
            we_q         <= we_d;
            rd_q         <= rd_d;
            data_q       <= data_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign stall        = stall_s;
    assign alu_ready    = grant_alu_s;
    assign lsu_ready    = grant_lsu_s;
    assign write_enable = we_q;
    assign rd           = rd_q;
    assign rd_data      = data_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the scoreboard and arbiter.
module tb_regfile_wb_arbiter;
    localparam int DW = 32;
    localparam int NR = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          issue_valid, issue_has_rd;
    logic [RW-1:0] issue_rs1, issue_rs2, issue_rd;
    logic          stall;
    logic          alu_valid, lsu_valid, alu_ready, lsu_ready;
    logic [RW-1:0] alu_rd, lsu_rd, rd;
    logic [DW-1:0] alu_data, lsu_data, rd_data;
    logic          write_enable;
    logic [NR-1:0] busy;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit [NR-1:0] m_busy;
    bit          m_last_alu;
    bit          m_we;
    bit [RW-1:0] m_rd;
    bit [DW-1:0] m_data;

    regfile_wb_arbiter #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .issue_has_rd(issue_has_rd), .stall(stall),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .write_enable(write_enable), .rd(rd), .rd_data(rd_data), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic bit e_stall();
        return !rst && issue_valid &&
               (m_busy[issue_rs1] || m_busy[issue_rs2] || (issue_has_rd && m_busy[issue_rd]));
    endfunction

    function automatic bit e_alu();
        return !rst && alu_valid && (!lsu_valid || !m_last_alu);
    endfunction

    function automatic bit e_lsu();
        return !rst && lsu_valid && (!alu_valid || m_last_alu);
    endfunction

    task automatic idle_inputs();
        issue_valid = 1'b0; issue_has_rd = 1'b0;
        issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    endtask

    // Advance the model by one edge using the current inputs, then clock the DUT.
    task automatic tick();
        bit ga, gl, acc;
        ga  = e_alu();
        gl  = e_lsu();
        acc = !rst && issue_valid && !e_stall();
        if (rst) begin
            m_busy = '0; m_last_alu = 1'b0; m_we = 1'b0; m_rd = '0; m_data = '0;
        end else begin
            if (m_we) m_busy[m_rd] = 1'b0;
            if (acc && issue_has_rd && issue_rd != 0) m_busy[issue_rd] = 1'b1;
            if (ga) begin
                m_we = (alu_rd != 0); m_rd = alu_rd; m_data = alu_data; m_last_alu = 1'b1;
            end else if (gl) begin
                m_we = (lsu_rd != 0); m_rd = lsu_rd; m_data = lsu_data; m_last_alu = 1'b0;
            end else begin
                m_we = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        alu_valid = 1'b1; lsu_valid = 1'b1; issue_valid = 1'b1; issue_rs1 = 5'd3;
        #1;
        checks++;
        if ({alu_ready, lsu_ready, stall} !== 3'b000) begin
            errors++; $display("FAIL reset_comb: got %b expected 000", {alu_ready, lsu_ready, stall});
        end
        tick();
        tick();
        checks++;
        if (write_enable !== 1'b0 || rd !== 5'd0 || rd_data !== 32'd0 || busy !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: got we=%b rd=%0d data=%h busy=%h expected 0/0/0/0",
                     write_enable, rd, rd_data, busy);
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_single_alu();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        checks++;
        if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
            errors++; $display("FAIL single_grant: got alu=%b lsu=%b expected 1 0", alu_ready, lsu_ready);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (write_enable !== 1'b1 || rd !== 5'd5 || rd_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_wb: got we=%b rd=%0d data=%h expected 1 5 deadbeef", write_enable, rd, rd_data);
        end
        checks++;
        if (busy !== 32'd0) begin
            errors++; $display("FAIL nonbusy_wb: got busy=%h expected 0", busy);
        end
        tick();
        checks++;
        if (write_enable !== 1'b0) begin
            errors++; $display("FAIL we_idle: got %b expected 0", write_enable);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA1A1A1A1;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'hB2B2B2B2;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (alu_ready !== (k % 2 == 0) || lsu_ready !== (k % 2 == 1)) begin
                errors++;
                $display("FAIL rr_grant%0d: got alu=%b lsu=%b expected %b %b",
                         k, alu_ready, lsu_ready, (k % 2 == 0), (k % 2 == 1));
            end
            if (k > 0) begin
                checks++;
                if (write_enable !== 1'b1 || rd !== ((k % 2 == 1) ? 5'd1 : 5'd2)) begin
                    errors++;
                    $display("FAIL rr_wb%0d: got we=%b rd=%0d expected 1 %0d",
                             k, write_enable, rd, (k % 2 == 1) ? 1 : 2);
                end
            end
            tick();
        end
        idle_inputs();
        #1;
        checks++;
        if (write_enable !== 1'b1 || rd !== 5'd2 || rd_data !== 32'hB2B2B2B2) begin
            errors++;
            $display("FAIL rr_last: got we=%b rd=%0d data=%h expected 1 2 b2b2b2b2", write_enable, rd, rd_data);
        end
        tick();
    endtask

    task automatic test_raw_hazard();
        issue_valid = 1'b1; issue_has_rd = 1'b1; issue_rd = 5'd7;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL raw_first: got %b expected 0", stall); end
        tick();
        issue_has_rd = 1'b0; issue_rd = 5'd0; issue_rs1 = 5'd7; issue_rs2 = 5'd0;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (stall !== 1'b1 || busy[7] !== 1'b1) begin
                errors++; $display("FAIL raw_stall%0d: got stall=%b busy7=%b expected 1 1", k, stall, busy[7]);
            end
            tick();
        end
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h00C0FFEE;
        #1;
        checks++;
        if (lsu_ready !== 1'b1 || stall !== 1'b1) begin
            errors++; $display("FAIL raw_lsu: got ready=%b stall=%b expected 1 1", lsu_ready, stall);
        end
        tick();
        lsu_valid = 1'b0;
        #1;
        checks++;
        if (write_enable !== 1'b1 || rd !== 5'd7 || stall !== 1'b1 || busy[7] !== 1'b1) begin
            errors++;
            $display("FAIL raw_commit: got we=%b rd=%0d stall=%b busy7=%b expected 1 7 1 1",
                     write_enable, rd, stall, busy[7]);
        end
        tick();
        checks++;
        if (stall !== 1'b0 || busy[7] !== 1'b0) begin
            errors++; $display("FAIL raw_release: got stall=%b busy7=%b expected 0 0", stall, busy[7]);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_zero_reg();
        issue_valid = 1'b1; issue_has_rd = 1'b1; issue_rd = 5'd0;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL zero_issue: got %b expected 0", stall); end
        tick();
        issue_has_rd = 1'b0; issue_rs1 = 5'd0;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h00001234;
        #1;
        checks++;
        if (stall !== 1'b0 || alu_ready !== 1'b1 || busy !== 32'd0) begin
            errors++;
            $display("FAIL zero_use: got stall=%b ready=%b busy=%h expected 0 1 0", stall, alu_ready, busy);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (write_enable !== 1'b0 || busy !== 32'd0) begin
            errors++; $display("FAIL zero_wb: got we=%b busy=%h expected 0 0", write_enable, busy);
        end
        tick();
    endtask

    task automatic test_set_wins();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33333333;
        tick();
        alu_valid = 1'b0;
        issue_valid = 1'b1; issue_has_rd = 1'b1; issue_rd = 5'd3;
        #1;
        checks++;
        if (write_enable !== 1'b1 || rd !== 5'd3 || stall !== 1'b0) begin
            errors++;
            $display("FAIL setwin_pre: got we=%b rd=%0d stall=%b expected 1 3 0", write_enable, rd, stall);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (busy[3] !== 1'b1) begin errors++; $display("FAIL setwin: got busy3=%b expected 1", busy[3]); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        issue_valid = 1'b1; issue_has_rd = 1'b1; issue_rd = 5'd3;
        tick();
        issue_rd = 5'd7;
        tick();
        idle_inputs();
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99999999;
        #1;
        checks++;
        if (busy !== 32'h00000088 || alu_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_pre: got busy=%h ready=%b expected 88 1", busy, alu_ready);
        end
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (write_enable !== 1'b1 || alu_ready !== 1'b0) begin
            errors++; $display("FAIL midrst_pend: got we=%b ready=%b expected 1 0", write_enable, alu_ready);
        end
        tick();
        checks++;
        if (busy !== 32'd0 || write_enable !== 1'b0 || rd !== 5'd0 || rd_data !== 32'd0) begin
            errors++;
            $display("FAIL midrst: got busy=%h we=%b rd=%0d data=%h expected 0 0 0 0",
                     busy, write_enable, rd, rd_data);
        end
        rst = 1'b0;
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        bit ga, gl;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            if (!alu_valid && $urandom_range(0, 1) == 1) begin
                alu_valid = 1'b1; alu_rd = RW'($urandom_range(0, 7)); alu_data = $urandom;
            end
            if (!lsu_valid && $urandom_range(0, 2) == 0) begin
                lsu_valid = 1'b1; lsu_rd = RW'($urandom_range(0, 7)); lsu_data = $urandom;
            end
            issue_valid  = ($urandom_range(0, 2) != 0);
            issue_has_rd = $urandom_range(0, 1) == 1;
            issue_rs1    = RW'($urandom_range(0, 7));
            issue_rs2    = RW'($urandom_range(0, 7));
            issue_rd     = RW'($urandom_range(0, 7));
            #1;
            checks++;
            if (stall !== e_stall() || alu_ready !== e_alu() || lsu_ready !== e_lsu()) begin
                errors++;
                $display("FAIL rand_comb c%0d: got stall=%b alu=%b lsu=%b expected %b %b %b",
                         c, stall, alu_ready, lsu_ready, e_stall(), e_alu(), e_lsu());
            end
            checks++;
            if (write_enable !== m_we || busy !== m_busy || (m_we && (rd !== m_rd || rd_data !== m_data))) begin
                errors++;
                $display("FAIL rand_state c%0d: got we=%b rd=%0d data=%h busy=%h expected %b %0d %h %h",
                         c, write_enable, rd, rd_data, busy, m_we, m_rd, m_data, m_busy);
            end
            ga = e_alu();
            gl = e_lsu();
            tick();
            if (ga) alu_valid = 1'b0;
            if (gl) lsu_valid = 1'b0;
        end
        rst = 1'b0;
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        m_busy = '0; m_last_alu = 1'b0; m_we = 1'b0; m_rd = '0; m_data = '0;
        test_reset();
        test_single_alu();
        test_round_robin();
        test_raw_hazard();
        test_zero_reg();
        test_set_wins();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-002 The block SHALL have parameter NUM_REGS, default 32, architectural register count; REG_BUS_WIDTH = $clog2(NUM_REGS), derived, not overridable.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with ports named as follows.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 issue_valid  input  1  decode wants to issue an instruction.
REQ-007 issue_rs1, issue_rs2, issue_rd  input  REG_BUS_WIDTH each  sources and destination of the issuing instruction.
REQ-008 issue_has_rd  input  1  issuing instruction writes a register.
REQ-009 stall  output  1  issue blocked by hazard (combinational).
REQ-010 alu_valid, alu_rd, alu_data  input  1 / REG_BUS_WIDTH / DATA_WIDTH  ALU writeback request.
REQ-011 alu_ready  output  1  ALU request granted this cycle (combinational).
REQ-012 lsu_valid, lsu_rd, lsu_data  input  1 / REG_BUS_WIDTH / DATA_WIDTH  load-unit writeback request.
REQ-013 lsu_ready  output  1  LSU request granted this cycle (combinational).
REQ-014 write_enable, rd, rd_data  output  1 / REG_BUS_WIDTH / DATA_WIDTH  registered drive of the register file write port.
REQ-015 busy  output  NUM_REGS  scoreboard bitmap, bit i = register i has a pending write.

Function
REQ-016 Handshake: transfer occurs when valid && ready; requesters SHALL hold valid, rd, data stable until accepted; ready SHALL never assert without its valid.
REQ-017 At most one of alu_ready/lsu_ready SHALL be high per cycle.
REQ-018 Single requester valid: it is granted that cycle.
REQ-019 Both valid: round-robin; grant the requester not granted last; last_grant updates only on a transfer.
REQ-020 Latency: transfer in cycle N -> write_enable=1, rd, rd_data presented in cycle N+1; write_enable=0 in any cycle following no transfer.
REQ-021 Transfer with rd==0: accepted (ready high), but write_enable SHALL stay 0 in N+1.
REQ-022 Issue accepted when issue_valid && !stall; accepted issue with issue_has_rd and issue_rd!=0 sets busy[issue_rd] at that edge.
REQ-023 stall = issue_valid && (busy[issue_rs1] || busy[issue_rs2] || (issue_has_rd && busy[issue_rd])).
REQ-024 busy[rd] SHALL clear on the edge ending a cycle in which write_enable=1 for that rd.
REQ-025 Same-edge set and clear of the same register: set wins, busy stays 1.
REQ-026 busy[0] SHALL be constant 0; rs/rd of 0 never cause stall.
REQ-027 Writebacks to non-busy registers SHALL be forwarded normally and leave busy unchanged.

Reset
REQ-028 While rst=1 at a rising edge: busy=0, write_enable=0, rd=0, rd_data=0, last_grant=LSU (ALU wins first contention).
REQ-029 While rst=1, alu_ready, lsu_ready and stall SHALL be 0 and no issue or transfer is accepted.
REQ-030 Reset asserted mid-operation SHALL discard any pending output write (write_enable=0 next cycle) and all busy bits.

Verification
REQ-031 After reset, alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF one cycle -> alu_ready=1 same cycle; next cycle write_enable=1, rd=5, rd_data=0xDEADBEEF.
REQ-032 Both valid for 4 cycles (alu_rd=1, lsu_rd=2) -> grants ALU, LSU, ALU, LSU; write_enable high 4 consecutive cycles.
REQ-033 Issue rd=7, then issue rs1=7 -> stall=1 until cycle after LSU writeback of x7 commits, then stall=0 and busy[7]=0.
REQ-034 Issue rd=0 then rs1=0; ALU writeback rd=0 data=0x1234 -> busy stays 0, no stall, alu_ready=1, write_enable stays 0.
REQ-035 Issue rd=3 in same cycle write_enable=1, rd=3 -> busy[3]=1 afterwards.
REQ-036 rst=1 while busy=0x0000_0088 and a transfer occurs -> next cycle busy=0, write_enable=0, rd=0, rd_data=0.
